// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage:
// FSM encoding, reset vector default, field widths.
package instruction_fetch_pkg;

   localparam int WORD_W = 32;
   localparam int JIDX_W = 26;

   localparam logic [WORD_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_pc_next_logic.sv
// Next-PC selection for the fetch stage.
// Priority: jump, taken branch, sequential.
module pc_next_logic
   import instruction_fetch_pkg::*;
(
   input  logic [WORD_W-1:0] pc,
   input  logic              jump,
   input  logic              branch,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_offset,
   input  logic [JIDX_W-1:0] jump_index,
   output logic [WORD_W-1:0] pc_plus4,
   output logic [WORD_W-1:0] next_pc
);

   logic [WORD_W-1:0] br_target;
   logic [WORD_W-1:0] jmp_target;
   logic              sel_jump;
   logic              sel_br;

   assign pc_plus4   = pc + 32'd4;
   assign br_target  = pc_plus4 + (branch_offset << 2);
   assign jmp_target = {pc_plus4[31:28], jump_index, 2'b00};

   // jump wins over a taken branch, so the selects are exclusive
   assign sel_jump = jump;
   assign sel_br   = !jump && branch && branch_taken;

   // pick the target for the instruction leaving ISSUE
   always_comb begin
      next_pc = pc_plus4;
      unique case (1'b1)
         sel_jump: next_pc = jmp_target;
         sel_br:   next_pc = br_target;
         default:  next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: IDLE -> FETCH -> ISSUE loop,
// one instruction presented per ISSUE, stall holds it.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              jump,
   input  logic              branch,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_offset,
   input  logic [JIDX_W-1:0] jump_index,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] ins_out,
   output logic              ins_valid,
   output logic [WORD_W-1:0] pc_out,
   output logic [WORD_W-1:0] pc_plus4
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] next_pc;

   // target is computed from the presented instruction's address
   pc_next_logic u_pc_next (
      .pc            (pc_out),
      .jump          (jump),
      .branch        (branch),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_pc)
   );

   assign imem_addr = pc;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state: ack only matters in FETCH, stall only in ISSUE
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (imem_ack) state_nxt = ISSUE;
         ISSUE:   if (!stall)   state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs decoded from state
   always_comb begin
      imem_req  = 1'b0;
      ins_valid = 1'b0;
      unique case (state)
         FETCH:   imem_req  = 1'b1;
         ISSUE:   ins_valid = 1'b1;
         default: ;
      endcase
   end

   // capture fetched word, advance pc when ISSUE releases
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= {RESET_VECTOR[31:2], 2'b00};
         ins_out <= '0;
         pc_out  <= '0;
      end else begin
         if (state == FETCH && imem_ack) begin
            ins_out <= imem_rdata;
            pc_out  <= pc;
         end
         if (state == ISSUE && !stall) begin
            pc <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a PC-sequence model
// predicts each presented instruction; a monitor checks them.
module tb_instruction_fetch;

   localparam logic [31:0] RV = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        jump;
   logic        branch;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic [25:0] jump_index;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ins_out;
   logic        ins_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];
   exp_t        cur;
   bit          has_cur = 0;
   bit          prev_valid = 0;
   logic [31:0] model_pc;

   instruction_fetch #(.RESET_VECTOR(RV)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .jump          (jump),
      .branch        (branch),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .ins_out       (ins_out),
      .ins_valid     (ins_valid),
      .pc_out        (pc_out),
      .pc_plus4      (pc_plus4)
   );

   always #5 clk = ~clk;

   // memory contents as a function of the word address
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      if (a == 32'h0) return 32'h2008_0005;
      return a ^ 32'hA5C3_0F1E ^ {a[15:0], a[31:16]};
   endfunction

   // architectural next-PC rule in plain arithmetic
   function automatic logic [31:0] ref_next(
      input logic [31:0] p, input bit j, b, t,
      input logic [31:0] off, input logic [25:0] idx);
      logic [31:0] p4;
      p4 = p + 32'd4;
      if (j) return (p4 & 32'hF000_0000) + ({6'd0, idx} * 4);
      if (b && t) return p4 + off * 4;
      return p4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // one cycle of stimulus, applied after a falling edge
   task automatic drive(input bit s, j, b, t,
                        input logic [31:0] off,
                        input logic [25:0] idx, input bit ack);
      stall         = s;
      jump          = j;
      branch        = b;
      branch_taken  = t;
      branch_offset = off;
      jump_index    = idx;
      imem_ack      = ack;
      imem_rdata    = imem_req ? mem_f(imem_addr) : $urandom;
      if (!rst && ins_valid && !s) begin
         model_pc = ref_next(model_pc, j, b, t, off, idx);
         exp_q.push_back('{model_pc, mem_f(model_pc)});
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input bit late_ack);
      rst           = 1'b1;
      stall         = $urandom;
      jump          = 1'b0;
      branch        = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = '0;
      jump_index    = '0;
      imem_ack      = late_ack ? 1'b0 : 1'($urandom);
      imem_rdata    = $urandom;
      exp_q.delete();
      model_pc = RV;
      exp_q.push_back('{RV, mem_f(RV)});
      @(negedge clk);
      chk("rst_valid", 32'(ins_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_ins", ins_out, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      rst        = 1'b0;
      stall      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, RV);
      chk("late_ack_ins", ins_out, 32'd0);
   endtask

   task automatic wait_issue();
      int n = 0;
      while (!ins_valid && n < 20) begin
         drive(0, 0, 0, 0, '0, '0, 1);
         n++;
      end
      checks++;
      if (!ins_valid) begin
         errors++;
         $display("FAIL issue_timeout: got ins_valid=0 expected 1");
      end
   endtask

   task automatic issue(input bit j, b, t, input logic [31:0] off,
                        input logic [25:0] idx,
                        input logic [31:0] exp_addr, input string nm);
      wait_issue();
      drive(0, j, b, t, off, idx, 0);
      chk({nm, "_req"}, 32'(imem_req), 32'd1);
      chk(nm, imem_addr, exp_addr);
   endtask

   // monitor: each new ISSUE pops one expected instruction
   always @(posedge clk) begin
      #1;
      if (rst) begin
         has_cur = 0;
      end else if (ins_valid) begin
         chk("req_in_issue", 32'(imem_req), 32'd0);
         if (!prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               has_cur = 0;
               $display("FAIL unexpected_issue: got pc_out=%h expected none",
                        pc_out);
            end else begin
               cur = exp_q.pop_front();
               has_cur = 1;
            end
         end
         if (has_cur) begin
            chk("sb_pc_out", pc_out, cur.pc);
            chk("sb_ins_out", ins_out, cur.ins);
            chk("sb_pc_plus4", pc_plus4, cur.pc + 32'd4);
         end
      end
      prev_valid = ins_valid && !rst;
   end

   initial begin
      rst = 1'b1;
      stall = 0; jump = 0; branch = 0; branch_taken = 0;
      branch_offset = '0; jump_index = '0;
      imem_ack = 0; imem_rdata = '0;
      model_pc = RV;
      do_reset(0);

      wait_issue();
      chk("seq_valid", 32'(ins_valid), 32'd1);
      chk("seq_ins", ins_out, 32'h2008_0005);
      chk("seq_pc", pc_out, 32'h0);
      issue(0, 0, 0, '0, '0, 32'h4, "seq_next");
      issue(1, 0, 0, '0, 26'h4, 32'h10, "jump_to_10");
      issue(0, 1, 1, 32'd3, '0, 32'h20, "br_fwd");
      issue(1, 0, 0, '0, 26'h4, 32'h10, "jump_back1");
      issue(0, 1, 1, 32'hFFFF_FFFF, '0, 32'h10, "br_back");
      issue(0, 1, 0, 32'd3, '0, 32'h14, "br_not_taken");
      issue(1, 0, 0, '0, 26'h4, 32'h10, "jump_back2");
      issue(0, 1, 1, 32'h0400_000B, '0, 32'h1000_0040, "br_far");
      issue(1, 1, 1, 32'd5, 26'h100, 32'h1000_0400, "jump_prio");

      wait_issue();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom, 26'($urandom), 1'($urandom));
         chk("stall_valid", 32'(ins_valid), 32'd1);
         chk("stall_ins", ins_out, mem_f(32'h1000_0400));
         chk("stall_pc", pc_out, 32'h1000_0400);
         chk("stall_req", 32'(imem_req), 32'd0);
      end
      issue(0, 0, 0, '0, '0, 32'h1000_0404, "after_stall");
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, '0, '0, 0);
         chk("wait_addr", imem_addr, 32'h1000_0404);
         chk("wait_valid", 32'(ins_valid), 32'd0);
      end

      issue(0, 1, 1, 32'h3BFF_FEFD, '0, 32'hFFFF_FFFC, "br_to_top");
      wait_issue();
      chk("wrap_plus4", pc_plus4, 32'h0);
      issue(0, 0, 0, '0, '0, 32'h0, "wrap_addr");
      issue(1, 0, 0, '0, 26'h4, 32'h10, "pre_rst_jump");
      do_reset(1);
      wait_issue();
      chk("restart_pc", pc_out, RV);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         r = $urandom;
         if ($urandom_range(0, 96) == 0) begin
            do_reset(1);
         end else begin
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0,
                  1'($urandom),
                  r[6] ? $urandom : {{26{r[5]}}, r[5:0]},
                  26'($urandom),
                  $urandom_range(0, 2) != 0);
         end
      end

      wait_issue();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
